// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage load/store handshake between pipeline and data memory
interface data_mem_responder_if;
  logic        MEM_enable;
  logic        MEM_RW;
  logic        MEM_size;
  logic [31:0] MEM_address;
  logic [31:0] MEM_data_in;
  logic [31:0] MEM_data_out;
  logic        MEM_stall;
  logic        MEM_done;
  logic        MEM_fault;
  modport master (
    output MEM_enable, MEM_RW, MEM_size, MEM_address, MEM_data_in,
    input  MEM_data_out, MEM_stall, MEM_done, MEM_fault
  );
  modport slave (
    input  MEM_enable, MEM_RW, MEM_size, MEM_address, MEM_data_in,
    output MEM_data_out, MEM_stall, MEM_done, MEM_fault
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-serial 256x8 big-endian data memory for the MEM stage; DMEM_MISALIGN_FAULT_EN enables misaligned-word faults
module data_mem_responder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  data_mem_responder_if.slave   bus,
  input  logic                  pl_we,
  input  logic [ADDR_W-1:0]     pl_addr,
  input  logic [7:0]            pl_data
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] a, a_in, a0, xa;
  logic [31:0]       wd, data_out;
  logic [23:0]       rbuf;
  logic [1:0]        cnt;
  logic              rw, done, fault;
  logic [7:0]        st_byte;
  logic              unused_hi;
  assign a_in = bus.MEM_address[ADDR_W-1:0];
  assign unused_hi = ^bus.MEM_address[31:ADDR_W];
`ifdef DMEM_MISALIGN_FAULT_EN
  logic misal;
  assign misal = bus.MEM_size & |a_in[1:0];
  assign a0 = a_in;
`else
  // Misaligned words silently round down to the containing word
  assign a0 = bus.MEM_size ? {a_in[ADDR_W-1:2], 2'b00} : a_in;
`endif
  assign xa = a + ADDR_W'(cnt);
  assign st_byte = 8'(wd >> {~cnt, 3'b000});
  assign bus.MEM_stall = bus.MEM_enable & (state != DONE);
  assign bus.MEM_done = done;
  assign bus.MEM_fault = fault;
  assign bus.MEM_data_out = data_out;
  // Preload is written first so a same-edge store to that byte overrides it
  always_ff @(posedge Clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (Reset) begin
      state <= IDLE;
      data_out <= '0;
      done <= 1'b0;
      fault <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      fault <= 1'b0;
      if (bus.MEM_enable) begin
        a <= a0;
        wd <= bus.MEM_data_in;
        rw <= bus.MEM_RW;
`ifdef DMEM_MISALIGN_FAULT_EN
        if (misal) begin
          state <= DONE;
          done <= 1'b1;
          fault <= 1'b1;
          if (bus.MEM_RW) data_out <= '0;
        end else
`endif
        begin
          if (!bus.MEM_RW) mem[a0] <= bus.MEM_size ? bus.MEM_data_in[31:24] : bus.MEM_data_in[7:0];
          if (bus.MEM_size) begin
            rbuf <= {16'b0, mem[a0]};
            cnt <= 2'd1;
            state <= XFER;
          end else begin
            if (bus.MEM_RW) data_out <= {24'b0, mem[a0]};
            state <= DONE;
            done <= 1'b1;
          end
        end
      end
    end else if (state == XFER) begin
      if (!rw) mem[xa] <= st_byte;
      rbuf <= {rbuf[15:0], mem[xa]};
      cnt <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        state <= DONE;
        done <= 1'b1;
        if (rw) data_out <= {rbuf, mem[xa]};
      end
    end else begin
      state <= IDLE;
      done <= 1'b0;
      fault <= 1'b0;
      cnt <= '0;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed tests against a byte-array reference model checked every cycle
module tb_data_mem_responder;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  data_mem_responder_if bus();
  data_mem_responder dut (
    .Clk(Clk), .Reset(Reset), .bus(bus),
    .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data)
  );
  always #5 Clk = ~Clk;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        chk = 1'b0;
  logic        exp_stall = 1'b0, exp_done = 1'b0, exp_fault = 1'b0;
  logic [31:0] exp_dout = '0;
  logic [7:0]  m [256];
  always @(negedge Clk) if (chk) begin
    n_cmp++;
    if ({bus.MEM_stall, bus.MEM_done, bus.MEM_fault, bus.MEM_data_out} !== {exp_stall, exp_done, exp_fault, exp_dout}) begin
      n_err++;
      $display("FAIL cycle t=%0t stall/done/fault/dout got %b/%b/%b/%h want %b/%b/%b/%h", $time,
               bus.MEM_stall, bus.MEM_done, bus.MEM_fault, bus.MEM_data_out, exp_stall, exp_done, exp_fault, exp_dout);
    end
  end
  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask
  task automatic pre(input logic [7:0] ad, input logic [7:0] d);
    pl_we = 1'b1;
    pl_addr = ad;
    pl_data = d;
    m[ad] = d;
    @(posedge Clk);
    #1 pl_we = 1'b0;
  endtask
  task automatic acc(input logic rw, input logic sz, input logic [31:0] addr, input logic [31:0] din);
    logic [7:0] a;
    int lat;
    logic f;
    a = addr[7:0];
    f = 1'b0;
    lat = sz ? 4 : 1;
    if (sz && a[1:0] != 2'b00) begin
`ifdef DMEM_MISALIGN_FAULT_EN
      f = 1'b1;
      lat = 1;
`else
      a[1:0] = 2'b00;
`endif
    end
    bus.MEM_enable = 1'b1;
    bus.MEM_RW = rw;
    bus.MEM_size = sz;
    bus.MEM_address = addr;
    bus.MEM_data_in = din;
    exp_stall = 1'b1;
    exp_done = 1'b0;
    repeat (lat) @(posedge Clk);
    #1;
    if (f) begin
      if (rw) exp_dout = '0;
    end else if (rw) begin
      exp_dout = sz ? {m[a], m[a+1], m[a+2], m[a+3]} : {24'h0, m[a]};
    end else if (sz) begin
      for (int i = 0; i < 4; i++) m[a+i] = din[31-8*i -: 8];
    end else begin
      m[a] = din[7:0];
    end
    exp_stall = 1'b0;
    exp_done = 1'b1;
    exp_fault = f;
    @(posedge Clk);
    #1;
    bus.MEM_enable = 1'b0;
    exp_done = 1'b0;
    exp_fault = 1'b0;
  endtask
  initial begin
    bus.MEM_enable = 1'b0;
    bus.MEM_RW = 1'b0;
    bus.MEM_size = 1'b0;
    bus.MEM_address = '0;
    bus.MEM_data_in = '0;
    repeat (2) @(posedge Clk);
    #1 chk = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    // 1: word load of preloaded bytes
    pre(8'h10, 8'h11); pre(8'h11, 8'h22); pre(8'h12, 8'h33); pre(8'h13, 8'h44);
    acc(1'b1, 1'b1, 32'h0000_0010, '0);
    pin("t1_word_load", bus.MEM_data_out, 32'h1122_3344);
    // 2: byte store/load, neighbours untouched
    pre(8'h20, 8'h5A); pre(8'h22, 8'h3C);
    acc(1'b0, 1'b0, 32'h0000_0021, 32'hFFFF_FFA5);
    pin("t2_store_keeps_dout", bus.MEM_data_out, 32'h1122_3344);
    acc(1'b1, 1'b0, 32'h0000_0021, '0);
    pin("t2_byte_load", bus.MEM_data_out, 32'h0000_00A5);
    acc(1'b1, 1'b0, 32'h0000_0020, '0);
    pin("t2_left_neighbour", bus.MEM_data_out, 32'h0000_005A);
    acc(1'b1, 1'b0, 32'h0000_0022, '0);
    pin("t2_right_neighbour", bus.MEM_data_out, 32'h0000_003C);
    // 3: word store, big-endian byte readback (upper address bits ignored)
    acc(1'b0, 1'b1, 32'hABCD_0040, 32'hDEAD_BEEF);
    acc(1'b1, 1'b0, 32'h0000_0040, '0); pin("t3_b0", bus.MEM_data_out, 32'h0000_00DE);
    acc(1'b1, 1'b0, 32'h0000_0041, '0); pin("t3_b1", bus.MEM_data_out, 32'h0000_00AD);
    acc(1'b1, 1'b0, 32'h0000_0042, '0); pin("t3_b2", bus.MEM_data_out, 32'h0000_00BE);
    acc(1'b1, 1'b0, 32'h0000_0043, '0); pin("t3_b3", bus.MEM_data_out, 32'h0000_00EF);
    // 4: misaligned word load
    pre(8'h40, 8'h01); pre(8'h41, 8'h02); pre(8'h42, 8'h03); pre(8'h43, 8'h04);
    acc(1'b1, 1'b1, 32'h0000_0042, '0);
`ifdef DMEM_MISALIGN_FAULT_EN
    pin("t4_fault_dout", bus.MEM_data_out, 32'h0000_0000);
`else
    pin("t4_forced_align", bus.MEM_data_out, 32'h0102_0304);
`endif
    // 5: reset during a word store
    pre(8'h80, 8'h00); pre(8'h81, 8'h00); pre(8'h82, 8'h00); pre(8'h83, 8'h00);
    bus.MEM_enable = 1'b1;
    bus.MEM_RW = 1'b0;
    bus.MEM_size = 1'b1;
    bus.MEM_address = 32'h0000_0080;
    bus.MEM_data_in = 32'hCAFE_F00D;
    exp_stall = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    bus.MEM_enable = 1'b0;
    exp_stall = 1'b0;
    exp_dout = '0;
    m[8'h80] = 8'hCA;
    m[8'h81] = 8'hFE;
    @(posedge Clk);
    #1;
    acc(1'b1, 1'b0, 32'h0000_0080, '0); pin("t5_b0", bus.MEM_data_out, 32'h0000_00CA);
    acc(1'b1, 1'b0, 32'h0000_0081, '0); pin("t5_b1", bus.MEM_data_out, 32'h0000_00FE);
    acc(1'b1, 1'b0, 32'h0000_0082, '0); pin("t5_b2", bus.MEM_data_out, 32'h0000_0000);
    acc(1'b1, 1'b0, 32'h0000_0083, '0); pin("t5_b3", bus.MEM_data_out, 32'h0000_0000);
    // 6: idle with preload traffic
    pl_we = 1'b1;
    pl_addr = 8'h05;
    pl_data = 8'h7E;
    m[8'h05] = 8'h7E;
    repeat (10) @(posedge Clk);
    #1 pl_we = 1'b0;
    acc(1'b1, 1'b0, 32'h0000_0005, '0);
    pin("t6_preload_load", bus.MEM_data_out, 32'h0000_007E);
    repeat (2) @(posedge Clk);
    #1 chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the MEM stage of the ARM pipeline.
- It answers the load/store requests that MEM_load_store_instr, MEM_load_instr and MEM_size launch from EX_MEM_PipelineReg.
- Storage is 256x8 and byte-serial; a word transfer takes one byte per cycle.
- MEM_stall freezes the PC and pipeline registers until the access completes.
- A preload port lets the bench load initial data, in the same way the instruction ROM is loaded.

Parameters:
DEPTH, 256, number of byte locations
ADDR_W, 8, address bits used; MEM_address[31:ADDR_W] ignored

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
MEM_enable  input  1  load/store request (MEM_load_store_instr)
MEM_RW  input  1  1 = load (read), 0 = store (write)
MEM_size  input  1  1 = word (32-bit), 0 = byte
MEM_address  input  32  byte address; big-endian, mem[A] = bits 31:24 of word
MEM_data_in  input  32  store data; byte store uses bits 7:0
MEM_data_out  output  32  load result
MEM_stall  output  1  high while a request is pending and not complete
MEM_done  output  1  one-cycle pulse, access complete
MEM_fault  output  1  misaligned word access, valid with MEM_done
pl_we  input  1  preload byte write
pl_addr  input  ADDR_W  preload address
pl_data  input  8  preload data

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - MEM_data_out=0, MEM_done=0, MEM_fault=0, byte counter=0.
  - Memory contents are NOT cleared.
- FSM states: IDLE, XFER, DONE.
- MEM_stall = MEM_enable & (state != DONE). It is combinational and depends on MEM_enable.
- IDLE:
  - If MEM_enable=1, latch address[ADDR_W-1:0], data_in, RW and size.
  - At the same edge, perform byte 0 of the access: the whole byte access, or word byte at A+0.
  - Byte access, or misaligned word: next state is DONE.
  - Aligned word: counter=1, next state is XFER.
- XFER:
  - Each edge accesses byte A+counter from the latched values; counter increments.
  - After byte 3, next state is DONE.
  - Inputs are ignored in XFER; only latched values are used.
- DONE:
  - MEM_done=1 and MEM_stall=0 for exactly one cycle; the pipeline advances at this edge.
  - Next state is always IDLE. Back-to-back requests therefore see one IDLE cycle with MEM_stall high.
- Latency, counting from the first cycle MEM_enable is seen in IDLE:
  - Byte: MEM_stall high 1 cycle; MEM_done on the 2nd cycle.
  - Word: MEM_stall high 4 cycles; MEM_done on the 5th cycle.
- Load data:
  - Byte load returns {24'b0, byte} (zero-extended).
  - Word load assembles big-endian bytes: A+0 goes to bits 31:24, A+3 to bits 7:0.
  - MEM_data_out updates at the edge entering DONE and holds until the next load completes.
  - Stores leave MEM_data_out unchanged.
- Store data:
  - Byte store writes data_in[7:0].
  - Word store writes data_in[31:24] at A+0 through data_in[7:0] at A+3.
- Aligned word accesses never wrap, since the maximum start address is 252.
- Preload:
  - pl_we writes pl_data to pl_addr at the clock edge in any state, including while Reset is high.
  - If a store writes the same byte in the same cycle, the store wins.
- Reset mid-access:
  - The FSM goes to IDLE at that edge with no MEM_done.
  - Bytes already stored remain; the access is abandoned.
- MEM_enable=0 in IDLE: stay in IDLE, MEM_stall=0, no memory change.

Optional Feature:
- Macro: DMEM_MISALIGN_FAULT_EN.
- Defined: a word access with address[1:0]!=0 performs no memory access and goes IDLE to DONE.
  - MEM_stall is high for 1 cycle.
  - MEM_fault=1 with MEM_done.
  - For a load, MEM_data_out=0.
- Undefined:
  - address[1:0] is forced to 00 and the access proceeds as an aligned word.
  - MEM_fault is tied to 0.

Test Plan:
1. Preload 0x11,0x22,0x33,0x44 at 0x10..0x13, then word load at 0x10 -> MEM_stall high 4 cycles, MEM_done on the 5th cycle, MEM_data_out=0x11223344.
2. Byte store 0xA5 to 0x21, then byte load at 0x21 -> each access has 1 stall cycle, MEM_data_out=0x000000A5, bytes 0x20 and 0x22 unchanged.
3. Word store 0xDEADBEEF at 0x40, then byte loads at 0x40..0x43 -> 0xDE, 0xAD, 0xBE, 0xEF in that order.
4. Word load at 0x42, with 0x40..0x43 preloaded 01,02,03,04:
   - Macro defined -> 1 stall cycle, MEM_fault=1, MEM_data_out=0.
   - Macro undefined -> 4 stall cycles, MEM_data_out=0x01020304, MEM_fault=0.
5. Word store 0xCAFEF00D at 0x80 (0x80..0x83 preloaded 0), Reset asserted in the cycle after the 2nd stall cycle -> 0x80=CA and 0x81=FE; 0x82 and 0x83 stay 00; no MEM_done; next cycle MEM_stall=MEM_enable, IDLE.
6. MEM_enable=0 for 10 cycles while pl_we writes 0x7E to 0x05 -> MEM_stall=0 and MEM_done=0 throughout; a subsequent byte load at 0x05 returns 0x0000007E.
